// File: rtl/wb_ic_rr_nxm.sv
// N x M Wishbone crossbar with per-slave round-robin arbitration, unmapped-address error responder and ACK watchdog.
// Grant registered one cycle after request; data path is combinational once granted; stalls follow the slave's ack.
module wb_ic_rr_nxm #(
   parameter int N_MASTERS      = 2,
   parameter int N_SLAVES       = 4,
   parameter int WB_ADDR_WIDTH  = 32,
   parameter int WB_DATA_WIDTH  = 32,
   parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_ADDR_BASE  = '0,
   parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_ADDR_LIMIT = '0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]      m_adr,
   input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]      m_dat_w,
   input  logic [N_MASTERS*(WB_DATA_WIDTH/8)-1:0]  m_sel,
   input  logic [N_MASTERS-1:0]                    m_cyc,
   input  logic [N_MASTERS-1:0]                    m_stb,
   input  logic [N_MASTERS-1:0]                    m_we,
   output logic [N_MASTERS*WB_DATA_WIDTH-1:0]      m_dat_r,
   output logic [N_MASTERS-1:0]                    m_ack,
   output logic [N_MASTERS-1:0]                    m_err,
   output logic [N_SLAVES*WB_ADDR_WIDTH-1:0]       s_adr,
   output logic [N_SLAVES*WB_DATA_WIDTH-1:0]       s_dat_w,
   output logic [N_SLAVES*(WB_DATA_WIDTH/8)-1:0]   s_sel,
   output logic [N_SLAVES-1:0]                     s_cyc,
   output logic [N_SLAVES-1:0]                     s_stb,
   output logic [N_SLAVES-1:0]                     s_we,
   input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]       s_dat_r,
   input  logic [N_SLAVES-1:0]                     s_ack,
   input  logic [N_SLAVES-1:0]                     s_err
);

   localparam int AW   = WB_ADDR_WIDTH;
   localparam int DW   = WB_DATA_WIDTH;
   localparam int SELW = DW / 8;
   localparam int MW   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int SW   = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam int CW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_OWN, ST_UNMAP} mst_state_t;

   mst_state_t           state   [N_MASTERS];
   logic [SW-1:0]        tgt     [N_MASTERS];
   logic [N_MASTERS-1:0] err_q;
   logic [N_MASTERS-1:0] unmap_err;
   logic [N_MASTERS-1:0] dec_hit;
   logic [SW-1:0]        dec_idx [N_MASTERS];

   logic [N_MASTERS-1:0] req     [N_SLAVES];
   logic [N_SLAVES-1:0]  gnt_vld;
   logic [MW-1:0]        gnt_idx [N_SLAVES];
   logic [MW-1:0]        ptr     [N_SLAVES];
   logic [MW-1:0]        pick    [N_SLAVES];
   logic [N_SLAVES-1:0]  found;
   logic [N_SLAVES-1:0]  rel;
   logic [N_SLAVES-1:0]  gnt_chg;
   logic [MW-1:0]        cand;

   logic [CW-1:0]        wd_cnt  [N_SLAVES];
   logic [N_SLAVES-1:0]  stall;
   logic [N_SLAVES-1:0]  fire;

   // Address decode: scanning downward lets the lowest matching slave win.
   always_comb begin
      for (int i = 0; i < N_MASTERS; i++) begin
         dec_hit[i] = 1'b0;
         dec_idx[i] = '0;
         for (int j = N_SLAVES - 1; j >= 0; j--) begin
            if (m_adr[i*AW +: AW] >= SLAVE_ADDR_BASE[j*AW +: AW] &&
                m_adr[i*AW +: AW] <= SLAVE_ADDR_LIMIT[j*AW +: AW]) begin
               dec_hit[i] = 1'b1;
               dec_idx[i] = SW'(j);
            end
         end
      end
   end

   // A master entering WAIT this edge already requests, giving the one-cycle grant latency.
   always_comb begin
      for (int j = 0; j < N_SLAVES; j++) begin
         for (int i = 0; i < N_MASTERS; i++) begin
            req[j][i] = m_cyc[i] &&
                        ((state[i] == ST_WAIT && tgt[i] == SW'(j)) ||
                         (state[i] == ST_IDLE && m_stb[i] && dec_hit[i] && dec_idx[i] == SW'(j)));
         end
      end
   end

   always_comb begin
      cand = '0;
      for (int j = 0; j < N_SLAVES; j++) begin
         rel[j]   = 1'b0;
         found[j] = 1'b0;
         pick[j]  = '0;
         for (int i = 0; i < N_MASTERS; i++) begin
            if (gnt_vld[j] && gnt_idx[j] == MW'(i) && !m_cyc[i])
               rel[j] = 1'b1;
         end
         for (int k = 0; k < N_MASTERS; k++) begin
            cand = MW'((int'(ptr[j]) + k) % N_MASTERS);
            for (int i = 0; i < N_MASTERS; i++) begin
               if (!found[j] && cand == MW'(i) && req[j][i]) begin
                  found[j] = 1'b1;
                  pick[j]  = MW'(i);
               end
            end
         end
         gnt_chg[j] = rel[j] || (!gnt_vld[j] && found[j]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         gnt_vld <= '0;
         for (int j = 0; j < N_SLAVES; j++) begin
            gnt_idx[j] <= '0;
            ptr[j]     <= '0;
         end
      end else begin
         for (int j = 0; j < N_SLAVES; j++) begin
            if (!gnt_vld[j] || rel[j]) begin
               gnt_vld[j] <= found[j];
               if (found[j]) begin
                  gnt_idx[j] <= pick[j];
                  ptr[j]     <= MW'((int'(pick[j]) + 1) % N_MASTERS);
               end
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_MASTERS; i++)
         unmap_err[i] = (state[i] == ST_UNMAP) && m_cyc[i] && m_stb[i] && !err_q[i];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         err_q <= '0;
         for (int i = 0; i < N_MASTERS; i++) begin
            state[i] <= ST_IDLE;
            tgt[i]   <= '0;
         end
      end else begin
         err_q <= unmap_err;
         for (int i = 0; i < N_MASTERS; i++) begin
            case (state[i])
               ST_IDLE: begin
                  if (m_cyc[i] && m_stb[i]) begin
                     if (dec_hit[i]) begin
                        state[i] <= ST_WAIT;
                        tgt[i]   <= dec_idx[i];
                     end else begin
                        state[i] <= ST_UNMAP;
                     end
                  end
               end
               ST_WAIT: begin
                  if (!m_cyc[i])
                     state[i] <= ST_IDLE;
                  else if (gnt_vld[tgt[i]] && gnt_idx[tgt[i]] == MW'(i))
                     state[i] <= ST_OWN;
               end
               default: begin
                  if (!m_cyc[i])
                     state[i] <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Watchdog expiry suppresses the slave strobe for the cycle the error is returned.
   always_comb begin
      s_adr   = '0;
      s_dat_w = '0;
      s_sel   = '0;
      s_cyc   = '0;
      s_stb   = '0;
      s_we    = '0;
      m_dat_r = '0;
      m_ack   = '0;
      m_err   = unmap_err;
      stall   = '0;
      fire    = '0;
      for (int j = 0; j < N_SLAVES; j++) begin
         for (int i = 0; i < N_MASTERS; i++) begin
            if (gnt_vld[j] && gnt_idx[j] == MW'(i)) begin
               fire[j]  = (TIMEOUT_CYCLES != 0) && (wd_cnt[j] == TO_VAL);
               stall[j] = m_cyc[i] && m_stb[i] && !s_ack[j] && !s_err[j];
               s_adr[j*AW +: AW]       = m_adr[i*AW +: AW];
               s_dat_w[j*DW +: DW]     = m_dat_w[i*DW +: DW];
               s_sel[j*SELW +: SELW]   = m_sel[i*SELW +: SELW];
               s_cyc[j]                = m_cyc[i];
               s_stb[j]                = m_stb[i] && !fire[j];
               s_we[j]                 = m_we[i];
               m_dat_r[i*DW +: DW]     = s_dat_r[j*DW +: DW];
               m_ack[i]                = s_ack[j];
               m_err[i]                = s_err[j] || fire[j];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int j = 0; j < N_SLAVES; j++)
            wd_cnt[j] <= '0;
      end else begin
         for (int j = 0; j < N_SLAVES; j++) begin
            if (fire[j] || gnt_chg[j] || s_ack[j] || s_err[j])
               wd_cnt[j] <= '0;
            else if (stall[j] && TIMEOUT_CYCLES != 0)
               wd_cnt[j] <= wd_cnt[j] + 1'b1;
         end
      end
   end

endmodule
